// File: rtl/esfa_pkg.sv
// Shared ESFA constants: field widths, metadata scope, evaluator opcodes
// and the sequencer state encoding.
package esfa_pkg;

  localparam int DATA_W   = 8;
  localparam int MAX_META = 7;

  localparam logic [2:0] OP_ENRANK = 3'd0;
  localparam logic [2:0] OP_DERANK = 3'd1;
  localparam logic [2:0] OP_MATCH  = 3'd2;
  localparam logic [2:0] OP_HANDLE = 3'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/esfa_rank_sequencer.sv
// Steps one shared ESFA evaluator across N_CELLS slots, one query at a
// time; returns the first matching cell over a valid/ready response port.
// Ports: req_* query in, eval_*/cell_* to evaluator, rsp_* result out.
module esfa_rank_sequencer #(
  parameter int N_CELLS  = 8,
  parameter int DATA_W   = esfa_pkg::DATA_W,
  parameter int MAX_META = esfa_pkg::MAX_META,
  parameter int IDX_W    = $clog2(N_CELLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_metadata,
  input  logic              req_is_metadata,
  output logic [2:0]        eval_op,
  output logic [DATA_W-1:0] eval_metadata,
  output logic              eval_is_metadata,
  output logic [IDX_W-1:0]  cell_idx,
  output logic              cell_en,
  input  logic              eval_bool,
  input  logic [DATA_W-1:0] eval_value,
  input  logic [DATA_W-1:0] eval_context,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_found,
  output logic [DATA_W-1:0] rsp_value,
  output logic [DATA_W-1:0] rsp_context,
  output logic [IDX_W-1:0]  rsp_idx
);

  import esfa_pkg::*;

  localparam logic [DATA_W-1:0] META_LIM =
    DATA_W'(MAX_META);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_CELLS - 1);

  state_t state;
  logic   in_scope;
  logic   last_cell;

  assign in_scope  = req_is_metadata &&
                     (req_metadata <= META_LIM);
  assign last_cell = (cell_idx == LAST_IDX);

  assign req_ready = (state == ST_IDLE);
  assign cell_en   = (state == ST_SCAN);
  assign rsp_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cell_idx         <= '0;
      eval_op          <= '0;
      eval_metadata    <= '0;
      eval_is_metadata <= 1'b0;
      rsp_found        <= 1'b0;
      rsp_value        <= '0;
      rsp_context      <= '0;
      rsp_idx          <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            eval_op          <= req_op;
            eval_metadata    <= req_metadata;
            eval_is_metadata <= req_is_metadata;
            cell_idx         <= '0;
            if (in_scope) begin
              state <= ST_SCAN;
            end else begin
              // Out-of-scope query: answer "not found" without scanning.
              rsp_found   <= 1'b0;
              rsp_value   <= '0;
              rsp_context <= '0;
              rsp_idx     <= '0;
              state       <= ST_DONE;
            end
          end
        end
        ST_SCAN: begin
          if (eval_bool) begin
            rsp_found   <= 1'b1;
            rsp_value   <= eval_value;
            rsp_context <= eval_context;
            rsp_idx     <= cell_idx;
            state       <= ST_DONE;
          end else if (last_cell) begin
            // Index stays at the last slot: no wrap.
            rsp_found   <= 1'b0;
            rsp_value   <= '0;
            rsp_context <= '0;
            rsp_idx     <= '0;
            state       <= ST_DONE;
          end else begin
            cell_idx <= cell_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esfa_rank_sequencer.sv
// Self-checking bench for esfa_rank_sequencer: directed scenarios plus
// randomized traffic compared cycle by cycle against a latency model.
module tb_esfa_rank_sequencer;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int IW = 3;
  localparam int MM = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [DW-1:0] req_metadata = '0;
  logic          req_is_metadata = 1'b0;
  logic [2:0]    eval_op;
  logic [DW-1:0] eval_metadata;
  logic          eval_is_metadata;
  logic [IW-1:0] cell_idx;
  logic          cell_en;
  logic          eval_bool;
  logic [DW-1:0] eval_value;
  logic [DW-1:0] eval_context;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_found;
  logic [DW-1:0] rsp_value;
  logic [DW-1:0] rsp_context;
  logic [IW-1:0] rsp_idx;

  logic [N-1:0]  match_vec = '0;
  logic [DW-1:0] cell_val [N];
  logic [DW-1:0] cell_ctx [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign eval_bool    = match_vec[cell_idx];
  assign eval_value   = cell_val[cell_idx];
  assign eval_context = cell_ctx[cell_idx];

  esfa_rank_sequencer #(
    .N_CELLS (N),
    .DATA_W  (DW),
    .MAX_META(MM)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_metadata    (req_metadata),
    .req_is_metadata (req_is_metadata),
    .eval_op         (eval_op),
    .eval_metadata   (eval_metadata),
    .eval_is_metadata(eval_is_metadata),
    .cell_idx        (cell_idx),
    .cell_en         (cell_en),
    .eval_bool       (eval_bool),
    .eval_value      (eval_value),
    .eval_context    (eval_context),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_found       (rsp_found),
    .rsp_value       (rsp_value),
    .rsp_context     (rsp_context),
    .rsp_idx         (rsp_idx)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a query is busy for m_lat cycles after accept, then holds
  // its result until rsp_ready.
  bit          m_live = 0;
  bit          m_busy = 0;
  int          m_t = 0;
  int          m_lat = 0;
  int          m_cidx = 0;
  logic [2:0]  m_op = '0;
  logic [7:0]  m_meta = '0;
  logic        m_ism = 1'b0;
  logic        m_found = 1'b0;
  logic [7:0]  m_val = '0;
  logic [7:0]  m_ctx = '0;
  int          m_idx = 0;
  logic        p_found;
  logic [7:0]  p_val;
  logic [7:0]  p_ctx;
  int          p_idx;

  task automatic publish();
    m_found = p_found;
    m_val   = p_val;
    m_ctx   = p_ctx;
    m_idx   = p_idx;
  endtask

  always @(posedge clk) begin
    int k;
    m_live = 1;
    if (rst) begin
      m_busy = 0; m_t = 0; m_lat = 0; m_cidx = 0;
      m_op = '0; m_meta = '0; m_ism = 1'b0;
      m_found = 1'b0; m_val = '0; m_ctx = '0; m_idx = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_op = req_op;
        m_meta = req_metadata;
        m_ism = req_is_metadata;
        m_busy = 1; m_t = 1; m_cidx = 0;
        k = -1;
        for (int i = N - 1; i >= 0; i--)
          if (match_vec[i]) k = i;
        if (!req_is_metadata || req_metadata > MM) begin
          m_lat = 1;
          p_found = 0; p_val = 0; p_ctx = 0; p_idx = 0;
        end else if (k >= 0) begin
          m_lat = k + 2;
          p_found = 1; p_val = cell_val[k];
          p_ctx = cell_ctx[k]; p_idx = k;
        end else begin
          m_lat = N + 1;
          p_found = 0; p_val = 0; p_ctx = 0; p_idx = 0;
        end
        if (m_lat == 1) publish();
      end
    end else if (m_t >= m_lat) begin
      if (rsp_ready) m_busy = 0;
    end else begin
      m_t++;
      if (m_t < m_lat) m_cidx = m_t - 1;
      else publish();
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("cell_en", 32'(cell_en), 32'(m_busy && m_t < m_lat));
      chk("rsp_valid", 32'(rsp_valid),
          32'(m_busy && m_t >= m_lat));
      chk("cell_idx", 32'(cell_idx), 32'(m_cidx));
      chk("rsp_found", 32'(rsp_found), 32'(m_found));
      chk("rsp_value", 32'(rsp_value), 32'(m_val));
      chk("rsp_context", 32'(rsp_context), 32'(m_ctx));
      chk("rsp_idx", 32'(rsp_idx), 32'(m_idx));
      chk("eval_op", 32'(eval_op), 32'(m_op));
      chk("eval_metadata", 32'(eval_metadata), 32'(m_meta));
      chk("eval_is_metadata", 32'(eval_is_metadata), 32'(m_ism));
    end
  end

  task automatic run_q(input logic [7:0] meta,
                       input logic ism,
                       input logic [N-1:0] mv,
                       input int hold,
                       output int lat,
                       output int en_cnt,
                       output int max_idx);
    @(negedge clk); #1;
    req_op = 3'($urandom);
    req_metadata = meta;
    req_is_metadata = ism;
    match_vec = mv;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; en_cnt = 0; max_idx = 0;
    for (int i = 0; i < 40 && lat == 0; i++) begin
      @(negedge clk);
      if (cell_en) begin
        en_cnt++;
        if (int'(cell_idx) > max_idx) max_idx = int'(cell_idx);
      end
      if (rsp_valid) lat = i + 1;
    end
    if (lat == 0) chk("rsp_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, en, mx, hits;
    for (int i = 0; i < N; i++) begin
      cell_val[i] = 8'(8'h10 + i);
      cell_ctx[i] = 8'(8'h20 + i);
    end
    cell_val[5] = 8'h05;
    cell_ctx[5] = 8'h05;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_cell_en", 32'(cell_en), 0);

    // Match at cell 5.
    run_q(8'd3, 1'b1, 8'b0010_0000, 0, lat, en, mx);
    chk("t1_latency", 32'(lat), 7);
    chk("t1_cell_en_cycles", 32'(en), 6);
    chk("t1_found", 32'(rsp_found), 1);
    chk("t1_value", 32'(rsp_value), 5);
    chk("t1_context", 32'(rsp_context), 5);
    chk("t1_idx", 32'(rsp_idx), 5);

    // Metadata beyond scope.
    run_q(8'd9, 1'b1, 8'b1111_1111, 0, lat, en, mx);
    chk("t2_latency", 32'(lat), 1);
    chk("t2_cell_en_cycles", 32'(en), 0);
    chk("t2_found", 32'(rsp_found), 0);
    chk("t2_value", 32'(rsp_value), 0);
    chk("t2_idx", 32'(rsp_idx), 0);

    // Metadata flagged invalid.
    run_q(8'd2, 1'b0, 8'b1111_1111, 0, lat, en, mx);
    chk("t3_latency", 32'(lat), 1);
    chk("t3_found", 32'(rsp_found), 0);

    // No match anywhere.
    run_q(8'd7, 1'b1, 8'b0000_0000, 0, lat, en, mx);
    chk("t4_latency", 32'(lat), 9);
    chk("t4_cell_en_cycles", 32'(en), 8);
    chk("t4_max_idx", 32'(mx), 7);
    chk("t4_idx_held", 32'(cell_idx), 7);
    chk("t4_found", 32'(rsp_found), 0);
    chk("t4_value", 32'(rsp_value), 0);

    // Two matches, lowest wins; response held 4 cycles.
    run_q(8'd0, 1'b1, 8'b0100_0100, 4, lat, en, mx);
    chk("t5_latency", 32'(lat), 4);
    chk("t5_idx", 32'(rsp_idx), 2);
    chk("t5_value", 32'(rsp_value), 32'h12);
    chk("t5_context", 32'(rsp_context), 32'h22);
    @(negedge clk);
    chk("t5_rsp_dropped", 32'(rsp_valid), 0);
    chk("t5_ready_again", 32'(req_ready), 1);
    run_q(8'd1, 1'b1, 8'b1000_0000, 0, lat, en, mx);
    chk("t5b_latency", 32'(lat), 9);
    chk("t5b_idx", 32'(rsp_idx), 7);

    // Reset mid-scan at cell 3.
    @(negedge clk); #1;
    match_vec = '0;
    req_metadata = 8'd4;
    req_is_metadata = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 20 && hits == 0; i++) begin
      @(negedge clk);
      if (cell_en && cell_idx == 3'd3) hits = 1;
    end
    chk("t6_reached_idx3", 32'(hits), 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req_ready", 32'(req_ready), 1);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_cell_en", 32'(cell_en), 0);
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    chk("t6_no_response", 32'(hits), 0);

    // Randomized traffic.
    repeat (3000) begin
      @(negedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_op = 3'($urandom);
      req_metadata = 8'($urandom_range(0, 11));
      req_is_metadata = ($urandom_range(0, 4) != 0);
      if (!m_busy) begin
        if ($urandom_range(0, 3) == 0) match_vec = '0;
        else match_vec = N'($urandom & $urandom);
        for (int i = 0; i < N; i++) begin
          cell_val[i] = 8'($urandom);
          cell_ctx[i] = 8'($urandom);
        end
      end
    end
    @(negedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/esfa_rank_sequencer.md
Name: esfa_rank_sequencer

Overview:
- Sequences one shared ESFA per-cell evaluator (the rank/handle match operator) across the N cell slots of the array store.
- Accepts one query at a time over a valid/ready request port.
- Steps a cell index through the slots, feeding the latched query to the evaluator, and stops at the first cell whose evaluator result bool is true.
- Returns found flag, value, context and matching cell index over a valid/ready response port.
- Sits between the ESFA command front end and the cell store / evaluator datapath.

Parameters:
- N_CELLS, 8, number of cell slots scanned (power of two, >=2)
- DATA_W, 8, width of handle, metadata, value and context fields
- MAX_META, 7, largest in-scope metadata value
- IDX_W, $clog2(N_CELLS), width of cell index

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  query present
- req_ready  out  1  sequencer can accept query
- req_op  in  3  evaluator opcode, passed through
- req_metadata  in  DATA_W  query metadata (target handle)
- req_is_metadata  in  1  metadata field is valid
- eval_op  out  3  latched opcode to evaluator
- eval_metadata  out  DATA_W  latched metadata to evaluator
- eval_is_metadata  out  1  latched flag to evaluator
- cell_idx  out  IDX_W  cell slot currently driven to store/evaluator
- cell_en  out  1  cell_idx valid this cycle
- eval_bool  in  1  evaluator match result for cell_idx (combinational, same cycle)
- eval_value  in  DATA_W  evaluator result value
- eval_context  in  DATA_W  evaluator result context
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_found  out  1  a cell matched
- rsp_value  out  DATA_W  matched value, 0 if none
- rsp_context  out  DATA_W  matched context, 0 if none
- rsp_idx  out  IDX_W  matched cell index, 0 if none

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, cell_en=0, cell_idx=0, rsp_valid=0, rsp_found=0, rsp_value=0, rsp_context=0, rsp_idx=0, eval_* =0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch op/metadata/is_metadata into eval_* and clear cell_idx.
    - If !req_is_metadata or req_metadata>MAX_META (out of scope), go to DONE with found=0, value/context/idx=0.
    - Else go to SCAN.
  - SCAN: req_ready=0, cell_en=1, evaluator sees cell_idx.
    - If eval_bool=1, capture eval_value, eval_context and cell_idx into rsp_*, set found=1, go to DONE.
    - Else if cell_idx==N_CELLS-1, go to DONE with found=0 and fields 0.
    - Else cell_idx++.
  - DONE: rsp_valid=1, cell_en=0, rsp_* held stable. On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency, counted in cycles from the accept edge to rsp_valid high:
  - match at cell k: k+2
  - no match: N_CELLS+1
  - out of scope: 1
- First match wins: lower index has priority, and later cells are not evaluated.
- cell_idx never wraps within a query; it saturates at N_CELLS-1 and is cleared on accept.
- req_ready is 0 in SCAN and DONE, so no back-to-back overlap. Minimum spacing between accepts is 2 cycles plus the scan length.
- rsp_ready held high in DONE: completes in one cycle. rsp_ready while not in DONE is ignored.
- rsp_* outputs retain the last response after leaving DONE, until the next capture.
- rst asserted in any state: next cycle is IDLE with reset values. The in-flight query is dropped and no response is produced.
- eval_* outputs stay constant from accept until the next accept.

Decomposition:
- Shared package esfa_pkg holds:
  - DATA_W, MAX_META, opcode localparams (OP_ENRANK etc.)
  - state enum (IDLE, SCAN, DONE)
- Single module; no sub-module needed. The scan counter and response capture register are inline.

Test Plan:
1. Reset, then query metadata=3, is_metadata=1; evaluator model matches at cell 5 with value=5, context=5 -> rsp_valid at accept+7; found=1, value=5, context=5, idx=5; cell_en high for cycles 1..6.
2. Query metadata=9 (>7) -> rsp_valid at accept+1; found=0, value=0, idx=0; cell_en never asserted.
3. Query with is_metadata=0, metadata=2 -> out-of-scope path; found=0 after 1 cycle.
4. No cell matches, N_CELLS=8 -> rsp_valid at accept+9; found=0, fields 0; cell_idx reached 7 and did not wrap.
5. Matches at cells 2 and 6 -> idx=2 reported. Hold rsp_ready=0 for 4 cycles -> rsp_valid and fields stable, req_ready=0. Then rsp_ready=1 -> IDLE; a new request accepted the following cycle.
6. Assert rst during SCAN at cell_idx=3 -> next cycle: IDLE, req_ready=1, rsp_valid=0, cell_en=0; no response emitted.
